// File: rtl/wb_arbiter_pkg.sv
// Shared widths and writeback request record for the writeback arbiter.
package wb_arbiter_pkg;

   localparam int WORD_SIZE_DEF       = 32;
   localparam int INSTR_TYPE_SZ_DEF   = 2;
   localparam int ROB_ENTRY_WIDTH_DEF = 3;
   localparam int NUM_REQ_DEF         = 3;

   typedef struct packed {
      logic [INSTR_TYPE_SZ_DEF-1:0]   instr_type;
      logic [WORD_SIZE_DEF-1:0]       pc;
      logic [WORD_SIZE_DEF-1:0]       result;
      logic [ROB_ENTRY_WIDTH_DEF-1:0] rob_id;
   } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational requester picker: first valid requester at or after ptr, wrapping.
// With ptr tied to zero this degenerates to fixed lowest-index priority.
module rr_picker #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         idx,
   output logic               any
);

   always_comb begin
      logic [3:0] valid_pad;
      logic [3:0] grant_pad;
      logic [1:0] pos;
      int         pos_i;
      valid_pad = '0;
      grant_pad = '0;
      pos       = 2'd0;
      pos_i     = 0;
      idx       = 2'd0;
      any       = 1'b0;
      valid_pad[NUM_REQ-1:0] = valid;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos_i = int'(ptr) + k;
         if (pos_i >= NUM_REQ) pos_i = pos_i - NUM_REQ;
         pos = 2'(pos_i);
         if (!any && valid_pad[pos]) begin
            grant_pad[pos] = 1'b1;
            idx            = pos;
            any            = 1'b1;
         end
      end
      grant = grant_pad[NUM_REQ-1:0];
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of NUM_REQ result producers into a registered output stage.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (0 wins).
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int WORD_SIZE       = WORD_SIZE_DEF,
   parameter int INSTR_TYPE_SZ   = INSTR_TYPE_SZ_DEF,
   parameter int ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEF,
   parameter int NUM_REQ         = NUM_REQ_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*INSTR_TYPE_SZ-1:0]   req_instr_type,
   input  logic [NUM_REQ*WORD_SIZE-1:0]       req_pc,
   input  logic [NUM_REQ*WORD_SIZE-1:0]       req_result,
   input  logic [NUM_REQ*ROB_ENTRY_WIDTH-1:0] req_rob_id,
   input  logic                               wb_ready,
   output logic                               wb_valid,
   output logic [INSTR_TYPE_SZ-1:0]           wb_instr_type,
   output logic [WORD_SIZE-1:0]               wb_pc,
   output logic [WORD_SIZE-1:0]               wb_result,
   output logic [ROB_ENTRY_WIDTH-1:0]         wb_rob_id,
   output logic [1:0]                         wb_grant_id
);

   // Handshake: a transfer happens on a posedge where valid and ready are both high.
   // Upstream req_ready is combinational and one-hot; downstream wb_valid is registered
   // and holds with all fields stable until wb_ready is seen.
   logic                       out_free;
   logic                       grant_en;
   logic [NUM_REQ-1:0]         pick_grant;
   logic [1:0]                 pick_idx;
   logic                       pick_any;
   logic [1:0]                 pick_ptr;
   logic [INSTR_TYPE_SZ-1:0]   sel_instr_type;
   logic [WORD_SIZE-1:0]       sel_pc;
   logic [WORD_SIZE-1:0]       sel_result;
   logic [ROB_ENTRY_WIDTH-1:0] sel_rob_id;

   assign out_free  = ~wb_valid | wb_ready;
   assign grant_en  = reset & out_free & ~flush & pick_any;
   assign req_ready = grant_en ? pick_grant : '0;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [1:0] rr_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= 2'd0;
      end else if (grant_en) begin
         rr_ptr <= (pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick_idx + 2'd1;
      end
   end

   assign pick_ptr = rr_ptr;
`else
   assign pick_ptr = 2'd0;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .valid (req_valid),
      .ptr   (pick_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // One-hot mux of the granted requester's packed fields.
   always_comb begin
      sel_instr_type = '0;
      sel_pc         = '0;
      sel_result     = '0;
      sel_rob_id     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_grant[k]) begin
            sel_instr_type = req_instr_type[k*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
            sel_pc         = req_pc[k*WORD_SIZE +: WORD_SIZE];
            sel_result     = req_result[k*WORD_SIZE +: WORD_SIZE];
            sel_rob_id     = req_rob_id[k*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid      <= 1'b0;
         wb_instr_type <= '0;
         wb_pc         <= '0;
         wb_result     <= '0;
         wb_rob_id     <= '0;
         wb_grant_id   <= 2'd0;
      end else if (flush) begin
         wb_valid <= 1'b0;
      end else if (out_free) begin
         if (pick_any) begin
            wb_valid      <= 1'b1;
            wb_instr_type <= sel_instr_type;
            wb_pc         <= sel_pc;
            wb_result     <= sel_result;
            wb_rob_id     <= sel_rob_id;
            wb_grant_id   <= pick_idx;
         end else begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, width of pc and result.
REQ-002 Parameter INSTR_TYPE_SZ, default 2, width of instruction type.
REQ-003 Parameter ROB_ENTRY_WIDTH, default 3, width of ROB id.
REQ-004 Parameter NUM_REQ, default 3, number of writeback requesters (0=ALU, 1=MEM, 2=MUL); legal range 2..4.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  pipeline flush; kills in-flight writeback.
REQ-008 req_valid  input  NUM_REQ  requester i has a result.
REQ-009 req_ready  output  NUM_REQ  requester i's result is accepted this cycle.
REQ-010 req_instr_type  input  NUM_REQ*INSTR_TYPE_SZ  packed per requester, requester i in slice i.
REQ-011 req_pc  input  NUM_REQ*WORD_SIZE  packed pc per requester.
REQ-012 req_result  input  NUM_REQ*WORD_SIZE  packed result per requester.
REQ-013 req_rob_id  input  NUM_REQ*ROB_ENTRY_WIDTH  packed ROB id per requester.
REQ-014 wb_ready  input  1  downstream writeback stage accepts the output.
REQ-015 wb_valid  output  1  registered output holds a valid writeback.
REQ-016 wb_instr_type, wb_pc, wb_result, wb_rob_id  output  INSTR_TYPE_SZ / WORD_SIZE / WORD_SIZE / ROB_ENTRY_WIDTH  registered fields of the granted requester.
REQ-017 wb_grant_id  output  2  index of the requester that produced the current output.

Function
REQ-018 Output register is "free" when wb_valid=0, or when wb_valid=1 and wb_ready=1.
REQ-019 When free and flush=0, exactly one valid requester is granted; req_ready is one-hot on that requester, combinational, same cycle.
REQ-020 When not free or flush=1, req_ready is all zero.
REQ-021 On grant, the next posedge loads the granted fields into the output register, sets wb_valid=1 and sets wb_grant_id; latency is 1 cycle from accepted request to wb_valid.
REQ-022 When free and no requester is valid, the next posedge clears wb_valid; data fields hold their value.
REQ-023 When wb_valid=1 and wb_ready=0, all outputs hold unchanged.
REQ-024 flush=1 clears wb_valid at the next posedge, regardless of wb_ready, and no new grant occurs that cycle.
REQ-025 Round-robin pointer rr_ptr (2 bits): search order starts at rr_ptr and wraps modulo NUM_REQ; after a grant to requester g, rr_ptr becomes (g+1) mod NUM_REQ.
REQ-026 rr_ptr is unchanged in cycles with no grant, including flush cycles.
REQ-027 Simultaneous wb_ready=1 and a new grant in the same cycle gives back-to-back output with no bubble.

Reset
REQ-028 reset=0 asynchronously forces wb_valid=0, wb_instr_type=0, wb_pc=0, wb_result=0, wb_rob_id=0, wb_grant_id=0 and rr_ptr=0.
REQ-029 While reset=0, req_ready is all zero.
REQ-030 An assertion of reset in mid-operation discards the held output, with no partial writeback.

Configuration
REQ-031 Macro WB_ARB_ROUND_ROBIN_EN selects the arbitration scheme.
REQ-032 With WB_ARB_ROUND_ROBIN_EN defined, arbitration follows REQ-025/026.
REQ-033 Without the macro, arbitration is fixed priority, lowest index wins (MEM > ALU > MUL is not used; strictly 0 > 1 > 2); rr_ptr is not instantiated.

Structure
REQ-034 WORD_SIZE, INSTR_TYPE_SZ and ROB_ENTRY_WIDTH defaults, plus a wb_req_t struct (instr_type, pc, result, rob_id), belong in the shared package.
REQ-035 Requester selection is one sub-module, rr_picker: inputs are the valid mask and the pointer; outputs are a one-hot grant and the index. It is purely combinational.

Verification
REQ-036 Reset: hold reset=0 with req_valid=3'b111 -> req_ready=0, wb_valid=0 and all outputs 0; release reset -> the first grant goes to requester 0.
REQ-037 Round robin with req_valid=3'b111 held and wb_ready=1 -> grants run 0,1,2,0 on consecutive cycles, and wb_rob_id follows the per-requester ids (e.g. 5,6,7,5).
REQ-038 Backpressure: wb_valid=1 with wb_pc=0x100, wb_ready=0 for 3 cycles -> outputs stable and req_ready=0; wb_ready=1 -> the next grant loads on the following edge with no bubble.
REQ-039 Flush: flush=1 while wb_valid=1 and wb_ready=0 -> wb_valid=0 next cycle, and rr_ptr unchanged.
REQ-040 Wrap: rr_ptr=2, req_valid=3'b011 -> grant 0, and rr_ptr becomes 1.
REQ-041 Macro undefined: req_valid=3'b110 for 4 cycles with wb_ready=1 -> requester 1 is granted every cycle.
